// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide, one step per clock.
//               Optional define MULDIV_FAST_MUL_EN: single-cycle multiply.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam int                c_CW   = $clog2(ITERS);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(ITERS - 1);
    localparam logic [XLEN-1:0]   c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_FIN  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_f3;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_op;
    logic              r_negq;
    logic              r_negr;
    logic              r_spec;
    logic [XLEN-1:0]   r_spec_res;
    logic [XLEN-1:0]   r_result;
    logic              r_done;

    // Operand conditioning at acceptance
    logic              w_s1, w_s2, w_neg1, w_neg2;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic              w_div0, w_ovf, w_spec, w_fast;
    logic [XLEN-1:0]   w_spec_res;
    logic [2*XLEN-1:0] w_acc_init;

    assign w_s1   = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b010) ||
                    (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    assign w_s2   = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b100) || (FUNCT3 == 3'b110);
    assign w_neg1 = w_s1 && DATA1[XLEN-1];
    assign w_neg2 = w_s2 && DATA2[XLEN-1];
    assign w_mag1 = w_neg1 ? (~DATA1 + 1'b1) : DATA1;
    assign w_mag2 = w_neg2 ? (~DATA2 + 1'b1) : DATA2;

    assign w_div0     = FUNCT3[2] && (DATA2 == '0);
    assign w_ovf      = FUNCT3[2] && !FUNCT3[0] && (DATA1 == c_MIN) && (DATA2 == '1);
    assign w_spec     = w_div0 || w_ovf;
    // Overflowed DIV returns the dividend itself (0x80000000)
    assign w_spec_res = w_div0 ? (FUNCT3[1] ? DATA1 : '1) : (FUNCT3[1] ? '0 : DATA1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fx1, w_fx2, w_fprod;
    assign w_fx1      = {{XLEN{w_neg1}}, DATA1};
    assign w_fx2      = {{XLEN{w_neg2}}, DATA2};
    assign w_fprod    = w_fx1 * w_fx2;
    assign w_fast     = !FUNCT3[2];
    assign w_acc_init = w_fast ? w_fprod
                               : {{XLEN{1'b0}}, (FUNCT3[2] ? w_mag1 : w_mag2)};
`else
    assign w_fast     = 1'b0;
    assign w_acc_init = {{XLEN{1'b0}}, (FUNCT3[2] ? w_mag1 : w_mag2)};
`endif

    // One iteration step of each algorithm
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN+1:0]   w_shift, w_diff;
    logic              w_div_ok;

    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_op};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
    assign w_shift    = {r_rem, r_acc[XLEN-1]};
    assign w_diff     = w_shift - {2'b00, r_op};
    assign w_div_ok   = !w_diff[XLEN+1];

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_remv, w_res;

    assign w_prod = r_negq ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_negq ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_remv = r_negr ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];

    always_comb begin
        w_res = '0;
        if (r_spec) begin
            w_res = r_spec_res;
        end else begin
            case (r_f3)
                3'b000:                 w_res = w_prod[XLEN-1:0];
                3'b001, 3'b010, 3'b011: w_res = w_prod[2*XLEN-1:XLEN];
                3'b100, 3'b101:         w_res = w_quo;
                default:                w_res = w_remv;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= c_S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (START) w_state_nxt = (w_spec || w_fast) ? c_S_FIN : c_S_CALC;
            c_S_CALC: if (r_cnt == c_LAST) w_state_nxt = c_S_FIN;
            c_S_FIN:  if (r_done) w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        BUSY   = (r_state != c_S_IDLE);
        DONE   = r_done;
        RESULT = r_result;
    end

    // Datapath: FIN spends one cycle loading RESULT, then one with DONE high
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt      <= '0;
            r_f3       <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_op       <= '0;
            r_negq     <= 1'b0;
            r_negr     <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (START) begin
                        r_f3       <= FUNCT3;
                        r_op       <= FUNCT3[2] ? w_mag2 : w_mag1;
                        r_acc      <= w_acc_init;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_negq     <= w_fast ? 1'b0 : (w_neg1 ^ w_neg2);
                        r_negr     <= w_neg1;
                        r_spec     <= w_spec;
                        r_spec_res <= w_spec_res;
                    end
                end
                c_S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_f3[2]) begin
                        r_rem             <= w_div_ok ? w_diff[XLEN:0] : w_shift[XLEN:0];
                        r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], w_div_ok};
                    end else begin
                        r_acc <= w_mul_next;
                    end
                end
                c_S_FIN: begin
                    if (!r_done) begin
                        r_result <= w_res;
                        r_done   <= 1'b1;
                    end else begin
                        r_done   <= 1'b0;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed table, random
//               ops against an arithmetic model, busy/reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [31:0] RESULT;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int failures = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
        .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // RV32M semantics straight from 64-bit arithmetic and the division operators
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] a32, b32, q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        a32 = a;
        b32 = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = a32 / b32; return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = a32 % b32; return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        START = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Counts edges after the accepting edge until DONE is seen (bounded)
    task automatic wait_done(input string name, output int n);
        n = 0;
        while (DONE !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for DONE after %0d cycles", name, n);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        @(negedge CLK);
        START = 1'b1; FUNCT3 = f3; DATA1 = a; DATA2 = b;
        @(negedge CLK);
        START = 1'b0; FUNCT3 = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom;
        check({name, " busy_after_accept"}, {31'b0, BUSY}, 32'd1);
        wait_done(name, n);
        if (n >= 100) begin
            do_reset();
            return;
        end
        check({name, " latency"}, n, lat);
        check({name, " result"}, RESULT, exp);
        @(negedge CLK);
        check({name, " done_busy_clear"}, {30'b0, DONE, BUSY}, 32'd0);
    endtask

    vec_t vecs[16];

    initial begin
        int n;
        logic [2:0]  f3;
        logic [31:0] a, b;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[12] = '{3'b100, 32'd9,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'b111, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 1};
        vecs[14] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[15] = '{3'b100, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 33};

        do_reset();
        check("reset_busy",   {31'b0, BUSY}, 32'd0);
        check("reset_done",   {31'b0, DONE}, 32'd0);
        check("reset_result", RESULT,        32'd0);

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'hFFFF_FFFF;
                1: b = 32'd0;
                2: b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d f3=%0d a=%08h b=%08h", i, f3, a, b), f3, a, b,
                   model(f3, a, b), model_lat(f3, a, b));
        end

        // START re-presented mid-operation must not disturb the DIV in flight
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b100; DATA1 = 32'hFFFF_FF9C; DATA2 = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        n = 0;
        while (DONE !== 1'b1 && n < 100) begin
            if (n == 9) begin
                START = 1'b1; FUNCT3 = 3'b000; DATA1 = 32'd3; DATA2 = 32'd5;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            n++;
        end
        START = 1'b0;
        check("busy_start latency", n, 33);
        check("busy_start result", RESULT, 32'hFFFF_FFF2);
        @(negedge CLK);
        check("busy_start busy_fall", {30'b0, DONE, BUSY}, 32'd0);
        repeat (40) @(negedge CLK);
        check("busy_start no_second_done", {31'b0, DONE}, 32'd0);

        // Reset at E15 aborts the DIVU; a START at E17 then completes normally
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b101; DATA1 = 32'd1000; DATA2 = 32'd3;
        @(negedge CLK);
        START = 1'b0;
        repeat (14) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort busy",   {31'b0, BUSY}, 32'd0);
        check("abort done",   {31'b0, DONE}, 32'd0);
        check("abort result", RESULT,        32'd0);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = 3'b110; DATA1 = 32'hFFFF_FF9C; DATA2 = 32'd7;
        @(negedge CLK);
        START = 1'b0;
        check("after_abort busy", {31'b0, BUSY}, 32'd1);
        wait_done("after_abort", n);
        check("after_abort latency", n, 33);
        check("after_abort result", RESULT, 32'hFFFF_FFFE);
        @(negedge CLK);
        check("after_abort done_clear", {30'b0, DONE, BUSY}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
